// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised oversampling UART receiver. It runs entirely on the
// OVERSAMPLE x baud clock and accepts frames made of one start bit, DATA_BITS
// data bits (LSB first), an optional parity bit and STOP_BITS stop bits.
// The receive path is:
//   2-flop synchroniser -> falling-edge start detect -> 3-sample majority vote
//   per bit -> shift register -> held output word with valid/ack handshake.
//
// Parameters
//   DATA_BITS   data bits per frame, 5..9
//   OVERSAMPLE  clk16x ticks per bit, even, 8..32
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//
// Ports
//   clk16x      in   sample clock (OVERSAMPLE x baud), the only clock
//   rst_n       in   synchronous reset, active low
//   rx          in   asynchronous serial line, idle high
//   data_ack    in   consumer takes the held word when high with data_valid
//   data_out    out  received word
//   data_valid  out  data_out and the flags hold a word not yet acknowledged
//   parity_err  out  parity mismatch on the held word (always 0 with PARITY=0)
//   frame_err   out  at least one stop bit of the held word voted 0
//   break_det   out  data, parity and first stop bit all voted 0
//   overrun     out  one-cycle pulse: an unacknowledged word was overwritten
//   busy        out  receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk16x,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  // Tick positions of the three votes and of the bit wrap.
  localparam logic [TW-1:0] T_EARLY = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID   = TW'(MID);
  localparam logic [TW-1:0] T_VOTE  = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic                 sync1_q;
  logic                 rs_q;
  logic                 rs_d_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic                 samp_early_q;
  logic                 samp_mid_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 stop_bad_q;
  logic                 first_stop_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 brk_q;
  logic                 ovr_q;
  logic                 busy_q;

  logic vote;
  logic at_vote;
  logic at_wrap;
  logic stop_bad;
  logic first_stop;
  logic par_err_now;
  logic brk_now;
  logic complete;

  // Bit decision and completion-time flag values. The current vote is folded
  // in directly because the word is loaded on the same edge as the last stop
  // vote, before stop_bad_q / first_stop_q could capture it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    par_err_now = 1'b0;

    vote       = (samp_early_q & samp_mid_q) | (samp_early_q & rs_q) | (samp_mid_q & rs_q);
    at_vote    = (tick_q == T_VOTE);
    at_wrap    = (tick_q == T_LAST);
    stop_bad   = stop_bad_q | ~vote;
    first_stop = (bit_q == '0) ? vote : first_stop_q;

    if (PARITY == 1) begin
      // Odd parity: data plus parity bit must hold an odd number of ones.
      par_err_now = ~(^shift_q ^ par_bit_q);
    end else if (PARITY == 2) begin
      par_err_now = ^shift_q ^ par_bit_q;
    end

    brk_now  = (shift_q == '0) && !first_stop && ((PARITY == 0) || !par_bit_q);
    complete = (state_q == S_STOP) && at_vote && (bit_q == LAST_STOP);
  end

  always_ff @(posedge clk16x) begin
    // NOTE: the reset is synchronous, so it is an ordinary branch inside the
    // clocked block rather than an entry in the sensitivity list.
    if (!rst_n) begin
      // NOTE: sequential state is written with <= only, so every register sees
      // the pre-edge value of every other register regardless of statement order.
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rs_q         <= 1'b1;
      rs_d_q       <= 1'b1;
      tick_q       <= '0;
      bit_q        <= '0;
      samp_early_q <= 1'b1;
      samp_mid_q   <= 1'b1;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      first_stop_q <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q <= rx;
      rs_q    <= sync1_q;
      rs_d_q  <= rs_q;

      if (tick_q == T_EARLY) samp_early_q <= rs_q;
      if (tick_q == T_MID)   samp_mid_q   <= rs_q;

      if (state_q != S_IDLE) begin
        tick_q <= at_wrap ? '0 : tick_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tick_q     <= '0;
          bit_q      <= '0;
          stop_bad_q <= 1'b0;
          // A falling edge is required, so a line held low after a break
          // never restarts reception by itself.
          if (rs_d_q && !rs_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (at_vote && vote) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (at_wrap) begin
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (at_vote) par_bit_q <= vote;
          if (at_wrap) state_q   <= S_STOP;
        end

        S_STOP: begin
          if (at_vote) begin
            stop_bad_q <= stop_bad;
            if (bit_q == '0) first_stop_q <= vote;
          end
          if (complete) begin
            // Leave on the last vote, not the wrap, so a start edge arriving
            // half a bit later is still seen from IDLE.
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
          end else if (at_wrap) begin
            bit_q <= bit_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Output word and handshake. A completion always wins over an ack; an
      // ack only matters when no new word lands on the same edge.
      ovr_q <= 1'b0;
      if (complete) begin
        data_q  <= shift_q;
        perr_q  <= par_err_now;
        ferr_q  <= stop_bad;
        brk_q   <= brk_now;
        valid_q <= 1'b1;
        ovr_q   <= valid_q & ~data_ack;
      end else if (valid_q && data_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
